arbiter_rr_ctrl: RTL and testbench

//  Round-robin arbiter sharing one resource among NUM_REQ requesters over request/grant lines.

---
 rtl/arbiter_pkg.sv | 34 +++
 rtl/arbiter_rr_ctrl_if.sv | 28 ++
 rtl/arbiter_rr_pick.sv | 18 +
 rtl/arbiter_rr_ctrl.sv | 111 +++++++++++
 tb/tb_arbiter_rr_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/arbiter_pkg.sv
// Shared arbiter types and the round-robin winner search used by the picker.
package arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_GAP} arb_state_e;

    typedef struct packed {
        logic       found;
        logic [3:0] id;
    } rr_pick_t;

    // Scan last+1, last+2 ... wrapping mod n; last itself is checked last.
    // Iterating from the far end lets the nearest asserted request overwrite the result.
    function automatic rr_pick_t rr_next(input logic [15:0] req, input logic [3:0] last,
                                         input int unsigned n);
        rr_pick_t   r;
        logic [4:0] idx;
        r   = '0;
        idx = '0;
        for (int unsigned i = 16; i >= 1; i--) begin
            if (i <= n) begin
                idx = 5'(last) + 5'(i);
                if (idx >= 5'(n)) begin
                    idx = idx - 5'(n);
                end
                if (req[idx[3:0]]) begin
                    r.found = 1'b1;
                    r.id    = idx[3:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/arbiter_rr_ctrl_if.sv
// Request/grant bundle between requesters and the arbiter; master is the grant side.
interface arbiter_rr_ctrl_if #(
    parameter int NUM_REQ = 2
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] request;
    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [ID_W-1:0]    grant_id;
    logic               timeout;

    modport master (
        input  request,
        output grant,
        output grant_vld,
        output grant_id,
        output timeout
    );

    modport slave (
        output request,
        input  grant,
        input  grant_vld,
        input  grant_id,
        input  timeout
    );
endinterface

// File: rtl/arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after last_id_i, zero latency.
module arbiter_rr_pick
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] request_i,
    input  logic [ID_W-1:0]    last_id_i,
    output logic               found_o,
    output logic [ID_W-1:0]    win_id_o
);
    rr_pick_t pick;

    assign pick     = rr_next(16'(request_i), 4'(last_id_i), NUM_REQ);
    assign found_o  = pick.found;
    assign win_id_o = ID_W'(pick.id);
endmodule

// File: rtl/arbiter_rr_ctrl.sv
// Round-robin arbiter, grant registered 1 cycle after request, held while requested, one GAP cycle
// between grants. Optional hold-time preemption under `ARB_TIMEOUT_EN.
module arbiter_rr_ctrl
    import arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    arbiter_rr_ctrl_if.master  arb
);
    localparam int ID_W = $clog2(NUM_REQ);

    arb_state_e         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic               grant_vld_q;
    logic [ID_W-1:0]    grant_id_q;
    logic [ID_W-1:0]    last_id_q;
    logic               found;
    logic [ID_W-1:0]    win_id;

    arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .request_i (arb.request),
        .last_id_i (last_id_q),
        .found_o   (found),
        .win_id_o  (win_id)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              timeout_q;
    logic              hold_max;
    logic              other_req;

    assign hold_max  = (hold_q == HOLD_W'(MAX_HOLD - 1));
    assign other_req = |(arb.request & ~grant_q);
    assign arb.timeout = timeout_q;
`else
    assign arb.timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
            last_id_q   <= ID_W'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            hold_q      <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state_q)
                ARB_IDLE, ARB_GAP: begin
                    if (found) begin
                        state_q     <= ARB_GRANT;
                        grant_q     <= NUM_REQ'(1) << win_id;
                        grant_vld_q <= 1'b1;
                        grant_id_q  <= win_id;
`ifdef ARB_TIMEOUT_EN
                        hold_q      <= '0;
`endif
                    end else begin
                        state_q <= ARB_IDLE;
                    end
                end
                ARB_GRANT: begin
                    if (!arb.request[grant_id_q]) begin
                        state_q     <= ARB_GAP;
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        grant_id_q  <= '0;
                        last_id_q   <= grant_id_q;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_max && other_req) begin
                        state_q     <= ARB_GAP;
                        grant_q     <= '0;
                        grant_vld_q <= 1'b0;
                        grant_id_q  <= '0;
                        last_id_q   <= grant_id_q;
                        timeout_q   <= 1'b1;
                    end else if (!hold_max) begin
                        // Saturate one short of MAX_HOLD so a late competitor preempts at once.
                        hold_q <= hold_q + 1'b1;
`endif
                    end
                end
                default: begin
                    state_q     <= ARB_IDLE;
                    grant_q     <= '0;
                    grant_vld_q <= 1'b0;
                    grant_id_q  <= '0;
                end
            endcase
        end
    end

    assign arb.grant     = grant_q;
    assign arb.grant_vld = grant_vld_q;
    assign arb.grant_id  = grant_id_q;
endmodule

// File: tb/tb_arbiter_rr_ctrl.sv
// Directed bench for arbiter_rr_ctrl with NUM_REQ=2, MAX_HOLD=4.
module tb_arbiter_rr_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    arbiter_rr_ctrl_if #(.NUM_REQ(2)) arb_if ();

    arbiter_rr_ctrl #(
        .NUM_REQ  (2),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic chk_gnt(input string tag, input logic [1:0] g, input logic id,
                           input logic tmo);
        chk({tag, "_grant"}, 32'(arb_if.grant), 32'(g));
        chk({tag, "_vld"}, 32'(arb_if.grant_vld), 32'(|g));
        chk({tag, "_id"}, 32'(arb_if.grant_id), 32'(id));
        chk({tag, "_tmo"}, 32'(arb_if.timeout), 32'(tmo));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        arb_if.request = 2'b11;

        // Reset holds everything low even with both requests up.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_gnt("reset", 2'b00, 1'b0, 1'b0);
        end

        // Single requester: three cycles of grant, then the GAP.
        rst = 1'b0;
        arb_if.request = 2'b00;
        tick();
        chk_gnt("idle", 2'b00, 1'b0, 1'b0);
        arb_if.request = 2'b01;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_gnt("single_hold", 2'b01, 1'b0, 1'b0);
        end
        arb_if.request = 2'b00;
        tick();
        chk_gnt("single_gap", 2'b00, 1'b0, 1'b0);
        tick();
        chk_gnt("single_idle", 2'b00, 1'b0, 1'b0);

        // Both requesting from reset release: 0 first, then alternate.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arb_if.request = 2'b11;
        tick();
        chk_gnt("both_first", 2'b01, 1'b0, 1'b0);
        tick();
        chk_gnt("both_hold", 2'b01, 1'b0, 1'b0);
        arb_if.request = 2'b10;
        tick();
        chk_gnt("both_gap0", 2'b00, 1'b0, 1'b0);
        tick();
        chk_gnt("both_g1", 2'b10, 1'b1, 1'b0);
        arb_if.request = 2'b11;
        tick();
        chk_gnt("both_g1_hold", 2'b10, 1'b1, 1'b0);
        arb_if.request = 2'b01;
        tick();
        chk_gnt("both_gap1", 2'b00, 1'b0, 1'b0);
        tick();
        chk_gnt("both_g0", 2'b01, 1'b0, 1'b0);
        arb_if.request = 2'b00;
        tick();
        chk_gnt("both_gap2", 2'b00, 1'b0, 1'b0);
        tick();
        chk_gnt("both_idle", 2'b00, 1'b0, 1'b0);

        // req1 mostly held, req0 pulses in each GAP: 10,00,01,00,10.
        arb_if.request = 2'b10;
        tick();
        chk_gnt("pulse_a", 2'b10, 1'b1, 1'b0);
        arb_if.request = 2'b00;
        tick();
        chk_gnt("pulse_b", 2'b00, 1'b0, 1'b0);
        arb_if.request = 2'b11;
        tick();
        chk_gnt("pulse_c", 2'b01, 1'b0, 1'b0);
        arb_if.request = 2'b10;
        tick();
        chk_gnt("pulse_d", 2'b00, 1'b0, 1'b0);
        tick();
        chk_gnt("pulse_e", 2'b10, 1'b1, 1'b0);

        // Contended long hold: preempted after MAX_HOLD cycles only when enabled.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arb_if.request = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_gnt("long_hold", 2'b01, 1'b0, 1'b0);
        end
        tick();
`ifdef ARB_TIMEOUT_EN
        chk_gnt("tmo_preempt", 2'b00, 1'b0, 1'b1);
        tick();
        chk_gnt("tmo_next", 2'b10, 1'b1, 1'b0);
        arb_if.request = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_gnt("tmo_sole", 2'b10, 1'b1, 1'b0);
        end
        arb_if.request = 2'b11;
        tick();
        chk_gnt("tmo_late", 2'b00, 1'b0, 1'b1);
        tick();
        chk_gnt("tmo_late_next", 2'b01, 1'b0, 1'b0);
`else
        chk_gnt("no_tmo_a", 2'b01, 1'b0, 1'b0);
        tick();
        chk_gnt("no_tmo_b", 2'b01, 1'b0, 1'b0);
`endif

        // Reset in the middle of a grant to requester 1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arb_if.request = 2'b10;
        tick();
        chk_gnt("mid_pre", 2'b10, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        chk_gnt("mid_rst", 2'b00, 1'b0, 1'b0);
        rst = 1'b0;
        arb_if.request = 2'b11;
        tick();
        chk_gnt("mid_after", 2'b01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
